// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared state enum, gain table and band helpers for eq_gain_sequencer
// EQ_SOFT_RAMP_EN adds the RAMP state and the per-sample stepping helper.
package eq_pkg;

    localparam logic [7:0] UNITY_GAIN = 8'h80;

    // Index with the 3-bit gain code; entry 0 sits in the low byte.
    localparam logic [7:0][7:0] GAIN_TABLE = {
        8'hFF, 8'hC0, 8'hA0, 8'h80, 8'h60, 8'h40, 8'h20, 8'h00
    };

    localparam logic [4:0] SW_RESET_VAL = {2'b00, 3'd4};

    // [0] = bass, [1] = mid, [2] = high
    typedef logic [2:0][7:0] band_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
`ifdef EQ_SOFT_RAMP_EN
        ST_COMMIT = 2'd2,
        ST_RAMP   = 2'd3
`else
        ST_COMMIT = 2'd2
`endif
    } eq_state_e;

    function automatic band_vec_t commit_targets(input band_vec_t cur,
                                                 input logic [1:0] mode,
                                                 input logic [2:0] code);
        band_vec_t t;
        t = cur;
        case (mode)
            2'b00:   t = {3{UNITY_GAIN}};
            2'b01:   t[0] = GAIN_TABLE[code];
            2'b10:   t[1] = GAIN_TABLE[code];
            default: t[2] = GAIN_TABLE[code];
        endcase
        return t;
    endfunction

`ifdef EQ_SOFT_RAMP_EN
    // Moves by at most step and lands exactly on target, so the result stays in 0x00..0xFF.
    function automatic logic [7:0] step_toward(input logic [7:0] gain,
                                               input logic [7:0] target,
                                               input logic [8:0] step);
        logic signed [8:0] diff;
        diff = $signed({1'b0, target}) - $signed({1'b0, gain});
        if (diff > $signed(step)) begin
            return gain + step[7:0];
        end else if (diff < -$signed(step)) begin
            return gain - step[7:0];
        end else begin
            return target;
        end
    endfunction
`endif

endpackage

// File: rtl/eq_gain_sequencer_if.sv
// rtl/eq_gain_sequencer_if.sv - switch inputs, sample strobe and band gain outputs of eq_gain_sequencer
interface eq_gain_sequencer_if;
    logic       sample_valid;
    logic [1:0] sw_mode;
    logic [2:0] sw_gain;
    logic [7:0] gain_bass;
    logic [7:0] gain_mid;
    logic [7:0] gain_high;
    logic       busy;
    logic       done;

    modport master (
        output sample_valid, sw_mode, sw_gain,
        input  gain_bass, gain_mid, gain_high, busy, done
    );

    modport slave (
        input  sample_valid, sw_mode, sw_gain,
        output gain_bass, gain_mid, gain_high, busy, done
    );
endinterface

// File: rtl/eq_sw_debounce.sv
// rtl/eq_sw_debounce.sv - switch change detection and SETTLE stability counter
module eq_sw_debounce
    import eq_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       count_en_i,
    input  logic [4:0] sw_i,
    output logic [4:0] sw_stable_o,
    output logic       stable_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [4:0]       sw_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             same;

    assign same = (sw_i == sw_prev_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!count_en_i || !same) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(DEBOUNCE_CYC)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_prev_q <= SW_RESET_VAL;
            cnt_q     <= '0;
        end else begin
            sw_prev_q <= sw_i;
            cnt_q     <= cnt_d;
        end
    end

    // The last stable cycle completes the count, so commit follows without an extra wait.
    assign stable_o    = count_en_i && same && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
    assign sw_stable_o = sw_prev_q;

endmodule

// File: rtl/eq_gain_sequencer.sv
// rtl/eq_gain_sequencer.sv - debounced switch-to-band-gain sequencer for the equalizer datapath
// Define EQ_SOFT_RAMP_EN to ramp gains per sample_valid; otherwise commits apply directly.
module eq_gain_sequencer
    import eq_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1024,
    parameter int RAMP_STEP    = 1
) (
    input logic                 clk,
    input logic                 reset_n,
    eq_gain_sequencer_if.slave  bus
);

    eq_state_e  state_q;
    eq_state_e  state_d;
    logic [4:0] sw;
    logic [4:0] sw_stable;
    logic [4:0] committed_q;
    logic [4:0] committed_d;
    band_vec_t  tgt_q;
    band_vec_t  tgt_d;
    band_vec_t  gain_q;
    band_vec_t  gain_d;
    logic       pending_q;
    logic       pending_d;
    logic       done_q;
    logic       done_d;
    logic       settle_ok;

    assign sw = {bus.sw_mode, bus.sw_gain};

    eq_sw_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk         (clk),
        .reset_n     (reset_n),
        .count_en_i  (state_q == ST_SETTLE),
        .sw_i        (sw),
        .sw_stable_o (sw_stable),
        .stable_o    (settle_ok)
    );

`ifdef EQ_SOFT_RAMP_EN
    localparam logic [8:0] STEP9 = (RAMP_STEP > 255) ? 9'd255 : 9'(RAMP_STEP);
`else
    logic unused_ramp;
    assign unused_ramp = bus.sample_valid ^ (RAMP_STEP != 0);
`endif

    always_comb begin
        state_d     = state_q;
        committed_d = committed_q;
        tgt_d       = tgt_q;
        gain_d      = gain_q;
        pending_d   = pending_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pending_d = 1'b0;
                if (sw != committed_q) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_ok) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // Commit the debounced sample, not a value that may have moved this cycle.
                committed_d = sw_stable;
                tgt_d       = commit_targets(tgt_q, sw_stable[4:3], sw_stable[2:0]);
`ifdef EQ_SOFT_RAMP_EN
                pending_d   = 1'b0;
                state_d     = ST_RAMP;
`else
                gain_d      = tgt_d;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
`endif
            end
`ifdef EQ_SOFT_RAMP_EN
            ST_RAMP: begin
                if (gain_q == tgt_q) begin
                    pending_d = 1'b0;
                    if (pending_q || (sw != committed_q)) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    if (sw != committed_q) begin
                        pending_d = 1'b1;
                    end
                    if (bus.sample_valid) begin
                        for (int b = 0; b < 3; b++) begin
                            gain_d[b] = step_toward(gain_q[b], tgt_q[b], STEP9);
                        end
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            committed_q <= SW_RESET_VAL;
            tgt_q       <= {3{UNITY_GAIN}};
            gain_q      <= {3{UNITY_GAIN}};
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            committed_q <= committed_d;
            tgt_q       <= tgt_d;
            gain_q      <= gain_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
        end
    end

    assign bus.gain_bass = gain_q[0];
    assign bus.gain_mid  = gain_q[1];
    assign bus.gain_high = gain_q[2];
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// tb/tb_eq_gain_sequencer.sv - directed table-driven bench for eq_gain_sequencer (EQ_SOFT_RAMP_EN aware)
module tb_eq_gain_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    eq_gain_sequencer_if bus();

    eq_gain_sequencer #(
        .DEBOUNCE_CYC (4),
        .RAMP_STEP    (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

`ifdef EQ_SOFT_RAMP_EN
    eq_gain_sequencer_if bus2();

    eq_gain_sequencer #(
        .DEBOUNCE_CYC (4),
        .RAMP_STEP    (16)
    ) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );
`endif

    typedef struct {
        logic [1:0] mode;
        logic [2:0] code;
        logic [7:0] bass;
        logic [7:0] mid;
        logic [7:0] high;
    } vec_t;

    vec_t vecs [10];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_gains(input string name, input logic [7:0] b,
                               input logic [7:0] m, input logic [7:0] h);
        check({name, "_bass"}, int'(bus.gain_bass), int'(b));
        check({name, "_mid"},  int'(bus.gain_mid),  int'(m));
        check({name, "_high"}, int'(bus.gain_high), int'(h));
    endtask

    task tick();
        @(posedge clk);
        #1;
        if (bus.done) done_cnt++;
    endtask

    task automatic set_sw(input logic [1:0] m, input logic [2:0] g);
        bus.sw_mode = m;
        bus.sw_gain = g;
    endtask

    task automatic wait_done(input string name, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
`ifdef EQ_SOFT_RAMP_EN
        bus.sample_valid = 1'b1;
`endif
        while (!got && lat < 600) begin
            tick();
            lat++;
            got = bus.done;
        end
        bus.sample_valid = 1'b0;
        check({name, "_done_seen"}, int'(got), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d0;

        bus.sample_valid = 1'b0;
        set_sw(2'b00, 3'd4);
`ifdef EQ_SOFT_RAMP_EN
        bus2.sample_valid = 1'b0;
        bus2.sw_mode      = 2'b00;
        bus2.sw_gain      = 3'd4;
`endif

        vecs[0] = '{2'b01, 3'd6, 8'hC0, 8'h80, 8'h80};
        vecs[1] = '{2'b10, 3'd0, 8'hC0, 8'h00, 8'h80};
        vecs[2] = '{2'b11, 3'd7, 8'hC0, 8'h00, 8'hFF};
        vecs[3] = '{2'b01, 3'd0, 8'h00, 8'h00, 8'hFF};
        vecs[4] = '{2'b00, 3'd1, 8'h80, 8'h80, 8'h80};
        vecs[5] = '{2'b11, 3'd3, 8'h80, 8'h80, 8'h60};
        vecs[6] = '{2'b10, 3'd5, 8'h80, 8'hA0, 8'h60};
        vecs[7] = '{2'b01, 3'd2, 8'h40, 8'hA0, 8'h60};
        vecs[8] = '{2'b10, 3'd4, 8'h40, 8'h80, 8'h60};
        vecs[9] = '{2'b01, 3'd7, 8'hFF, 8'h80, 8'h60};

        // reset state and idle after release with the reset switch value
        repeat (3) @(posedge clk);
        #1;
        check_gains("in_reset", 8'h80, 8'h80, 8'h80);
        check("in_reset_busy", int'(bus.busy), 0);
        check("in_reset_done", int'(bus.done), 0);
        reset_n = 1'b1;
        repeat (8) tick();
        check_gains("post_reset", 8'h80, 8'h80, 8'h80);
        check("post_reset_busy", int'(bus.busy), 0);
        check("post_reset_done_cnt", done_cnt, 0);

        for (int i = 0; i < 10; i++) begin
            set_sw(vecs[i].mode, vecs[i].code);
            wait_done($sformatf("vec%0d", i), lat);
`ifndef EQ_SOFT_RAMP_EN
            check($sformatf("vec%0d_latency", i), lat, 6);
`endif
            check_gains($sformatf("vec%0d", i), vecs[i].bass, vecs[i].mid, vecs[i].high);
            check($sformatf("vec%0d_busy", i), int'(bus.busy), 0);
            tick();
            check($sformatf("vec%0d_done_pulse", i), int'(bus.done), 0);
        end

        // a change after three stable cycles restarts the debounce count
        set_sw(2'b11, 3'd5);
        repeat (3) tick();
        set_sw(2'b11, 3'd1);
        wait_done("restart", lat);
`ifndef EQ_SOFT_RAMP_EN
        check("restart_latency", lat, 6);
`endif
        check_gains("restart", 8'hFF, 8'h80, 8'h20);
        tick();

        // switches toggling every two cycles never commit
        d0 = done_cnt;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) set_sw(2'b10, (i % 4 == 0) ? 3'd3 : 3'd6);
            tick();
            check($sformatf("toggle_busy%0d", i), int'(bus.busy), 1);
        end
        check("toggle_no_done", done_cnt - d0, 0);
        check_gains("toggle_hold", 8'hFF, 8'h80, 8'h20);
        wait_done("toggle_end", lat);
        check_gains("toggle_end", 8'hFF, 8'hC0, 8'h20);
        tick();

        // reset mid-SETTLE restores unity at once, with no done
        set_sw(2'b10, 3'd0);
        repeat (2) tick();
        check("settle_busy", int'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        check_gains("async_reset", 8'h80, 8'h80, 8'h80);
        check("async_reset_busy", int'(bus.busy), 0);
        check("async_reset_done", int'(bus.done), 0);
        set_sw(2'b00, 3'd4);
        #2;
        reset_n = 1'b1;
        d0 = done_cnt;
        repeat (6) tick();
        check("after_reset_busy", int'(bus.busy), 0);
        check("after_reset_no_done", done_cnt - d0, 0);
        check_gains("after_reset", 8'h80, 8'h80, 8'h80);

`ifdef EQ_SOFT_RAMP_EN
        // bass ramps one step per strobe; a mid-ramp change is deferred to a second pass
        d0 = done_cnt;
        set_sw(2'b01, 3'd6);
        repeat (6) tick();
        check("ramp_entry_busy", int'(bus.busy), 1);
        check("ramp_entry_bass", int'(bus.gain_bass), 8'h80);
        for (int k = 1; k <= 64; k++) begin
            bus.sample_valid = 1'b1;
            tick();
            bus.sample_valid = 1'b0;
            check($sformatf("bass_ramp%0d", k), int'(bus.gain_bass), 128 + k);
            if (k == 10) set_sw(2'b11, 3'd0);
            tick();
        end
        check("pending_no_done", done_cnt - d0, 0);
        check("pending_busy", int'(bus.busy), 1);
        check_gains("bass_final", 8'hC0, 8'h80, 8'h80);
        repeat (5) tick();
        for (int k = 1; k <= 128; k++) begin
            bus.sample_valid = 1'b1;
            tick();
            bus.sample_valid = 1'b0;
            check($sformatf("high_ramp%0d", k), int'(bus.gain_high), 128 - k);
            tick();
        end
        check("second_pass_done", int'(bus.done), 1);
        check("single_done", done_cnt - d0, 1);
        check_gains("high_final", 8'hC0, 8'h80, 8'h00);

        // large step lands exactly on 0xFF
        bus2.sw_mode = 2'b11;
        bus2.sw_gain = 3'd7;
        repeat (6) tick();
        for (int k = 0; k < 8; k++) begin
            bus2.sample_valid = 1'b1;
            tick();
            bus2.sample_valid = 1'b0;
            check($sformatf("step16_%0d", k), int'(bus2.gain_high), (k < 7) ? (8'h90 + 16 * k) : 8'hFF);
            tick();
        end
        check("step16_done", int'(bus2.done), 1);
        check("step16_bass", int'(bus2.gain_bass), 8'h80);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eq_gain_sequencer.md
EQ_GAIN_SEQUENCER -- requirements
Module: eq_gain_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1024: number of consecutive cycles switches must stay stable before commit.
REQ-002 Parameter RAMP_STEP, default 1: maximum gain change per sample_valid per band.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sample_valid  input  1  one-cycle strobe per audio sample; paces ramping.
REQ-006 sw_mode  input  2  band select: 00 flat/all unity, 01 bass, 10 mid, 11 high.
REQ-007 sw_gain  input  3  gain code for the selected band.
REQ-008 gain_bass, gain_mid, gain_high  output  8 each  unsigned Q1.7 band gains to the equalizer datapath (0x80 = unity).
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse when the sequence returns to IDLE after a commit.

Function
REQ-011 The block SHALL map gain codes via a fixed table: 0→0x00, 1→0x20, 2→0x40, 3→0x60, 4→0x80, 5→0xA0, 6→0xC0, 7→0xFF.
REQ-012 The FSM SHALL have states IDLE, SETTLE, COMMIT, RAMP.
REQ-013 IDLE→SETTLE when {sw_mode,sw_gain} differs from the last committed value.
REQ-014 SETTLE SHALL count consecutive cycles with unchanged {sw_mode,sw_gain}. Any change restarts the count at 0. Reaching DEBOUNCE_CYC → COMMIT.
REQ-015 COMMIT (one cycle) SHALL record {sw_mode,sw_gain} as committed and update band targets, then go to RAMP:
- mode 01/10/11: the selected band's target = table value; other targets unchanged.
- mode 00: all three targets = 0x80.
REQ-016 In RAMP, on each cycle with sample_valid=1, every band gain SHALL move toward its target by min(RAMP_STEP, |target−gain|). Without sample_valid, gains hold.
REQ-017 RAMP→IDLE on the cycle after all three gains equal their targets; done SHALL pulse on that IDLE-entry cycle.
REQ-018 If switches change during RAMP, a pending flag SHALL be set; targets are not altered mid-ramp. On ramp completion with pending set, go to SETTLE instead of IDLE, with no done pulse.
REQ-019 If a commit leaves every target already equal to its gain, RAMP SHALL exit on its first cycle.
REQ-020 Gain arithmetic SHALL use 9-bit signed difference. Results SHALL never wrap below 0x00 or above 0xFF.
REQ-021 Gain outputs SHALL be registered and change only in RAMP (or COMMIT per REQ-026).

Reset
REQ-022 Assertion of reset_n=0 SHALL, asynchronously:
- set gains and targets to 0x80;
- set state to IDLE;
- set busy=0 and done=0;
- clear pending and the debounce counter;
- set committed value to {00,3'd4}.
REQ-023 Reset mid-RAMP or mid-SETTLE SHALL abandon the sequence with no done pulse.

Configuration
REQ-024 Macro EQ_SOFT_RAMP_EN SHALL select the ramping feature.
REQ-025 With EQ_SOFT_RAMP_EN defined, behaviour is per REQ-016..019.
REQ-026 Without it, the RAMP state and RAMP_STEP logic SHALL be absent:
- COMMIT writes targets directly to gain outputs and goes to IDLE;
- done pulses on the next cycle;
- sample_valid is ignored.

Structure
REQ-027 Package eq_pkg SHALL hold the FSM state enum, the gain code table constant, and the UNITY_GAIN (0x80) constant.
REQ-028 Sub-module eq_sw_debounce SHALL implement the SETTLE stability counter and change detection.

Verification (DEBOUNCE_CYC=4, RAMP_STEP=1 unless noted)
REQ-029 Reset release with sw={00,100} → gains stay 0x80, busy=0, no done.
REQ-030 Set sw={01,110}, hold 4 cycles → COMMIT. Then 64 sample_valid strobes → gain_bass rises 0x80→0xC0 one per strobe. done pulses once; mid/high stay 0x80.
REQ-031 sw toggles every 2 cycles for 20 cycles → no commit, gains unchanged, busy high throughout.
REQ-032 During the REQ-030 ramp, change to {11,000} → bass finishes at 0xC0, then SETTLE. After debounce, gain_high ramps 0x80→0x00 with a single done at the end.
REQ-033 RAMP_STEP=16, target 0xFF from 0x80 → gain values 0x90…0xF0, then 0xFF; no overshoot.
REQ-034 Without EQ_SOFT_RAMP_EN, sw={10,000} held 4 cycles → gain_mid=0x00 on the cycle after COMMIT, done next cycle. Assert reset_n mid-SETTLE → all gains 0x80 immediately.
